// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer bank: command encodings,
// per-channel FSM states, time-field limits and the mm:ss.cc field struct.
// Build option: TIMER_AUTO_RELOAD_EN (see timer_channel).
package timer_pkg;

  // Command opcodes carried on cmdOp; encodings 6 and 7 are rejected.
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_START = 3'd2,
    OP_PAUSE = 3'd3,
    OP_CLEAR = 3'd4,
    OP_ACK   = 3'd5
  } cmd_op_e;

  // Per-channel lifecycle.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOADED,
    ST_RUNNING,
    ST_PAUSED,
    ST_RINGING
  } chan_state_e;

  // Largest legal value of each sub-hour field; also the borrow targets.
  localparam logic [5:0] MM_MAX = 6'd59;
  localparam logic [5:0] SS_MAX = 6'd59;
  localparam logic [6:0] CC_MAX = 7'd99;

  // Minutes, seconds and centiseconds. Hours are kept separately because
  // their width is a module parameter.
  typedef struct packed {
    logic [5:0] mm;
    logic [5:0] ss;
    logic [6:0] cc;
  } msc_t;

  // True when every sub-hour field of a LOAD value is in range.
  function automatic logic msc_fields_ok(msc_t t);
    return (t.mm <= MM_MAX) && (t.ss <= SS_MAX) && (t.cc <= CC_MAX);
  endfunction

endpackage

// File: rtl/countdown_timer_bank_if.sv
// Command port of the countdown timer bank: a one-cycle command strobe with
// its payload, plus the registered rejection pulse returned to the issuer.
interface countdown_timer_bank_if #(
  parameter int CH_W    = 2,
  parameter int HOURS_W = 5
) ();

  logic               cmdValid;
  logic [2:0]         cmdOp;
  logic [CH_W-1:0]    cmdChannel;
  logic [HOURS_W-1:0] loadHours;
  logic [5:0]         loadMinutes;
  logic [5:0]         loadSeconds;
  logic [6:0]         loadCentis;
  logic               cmdError;

  // Command issuer (CPU side / testbench).
  modport master (
    output cmdValid, cmdOp, cmdChannel,
    output loadHours, loadMinutes, loadSeconds, loadCentis,
    input  cmdError
  );

  // Timer bank side.
  modport slave (
    input  cmdValid, cmdOp, cmdChannel,
    input  loadHours, loadMinutes, loadSeconds, loadCentis,
    output cmdError
  );

endinterface

// File: rtl/timer_channel.sv
// One countdown channel: lifecycle FSM, hh:mm:ss.cc borrow counter and the
// reload register. Commands arrive pre-validated from the bank; a command in
// the same cycle as a tick takes precedence and that tick is dropped.
// Build option TIMER_AUTO_RELOAD_EN: on expiry a non-zero reload value is
// copied back into the count and the channel keeps RUNNING with ring latched.
module timer_channel
  import timer_pkg::*;
#(
  parameter int HOURS_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic               cmd_en_i,
  input  cmd_op_e            cmd_op_i,
  input  logic [HOURS_W-1:0] load_hours_i,
  input  msc_t               load_msc_i,
  output logic [HOURS_W-1:0] hours_o,
  output msc_t               msc_o,
  output logic               running_o,
  output logic               ring_o
);

  chan_state_e        state_q;
  logic [HOURS_W-1:0] hours_q;
  msc_t               msc_q;
  logic               ring_q;

  logic [HOURS_W-1:0] hours_dec;
  msc_t               msc_dec;
  logic               is_zero;

  logic [HOURS_W-1:0] rel_hours;
  msc_t               rel_msc;
  logic               reload_ok;

  chan_state_e        exp_state;
  logic [HOURS_W-1:0] exp_hours;
  msc_t               exp_msc;

  assign is_zero = (hours_q == '0) && (msc_q == '0);

  // Borrow chain: cc -> ss -> mm -> hh. Only used when the count is non-zero,
  // so hours never underflow.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    hours_dec = hours_q;
    msc_dec   = msc_q;
    if (msc_q.cc != '0) begin
      msc_dec.cc = msc_q.cc - 7'd1;
    end else begin
      msc_dec.cc = CC_MAX;
      if (msc_q.ss != '0) begin
        msc_dec.ss = msc_q.ss - 6'd1;
      end else begin
        msc_dec.ss = SS_MAX;
        if (msc_q.mm != '0) begin
          msc_dec.mm = msc_q.mm - 6'd1;
        end else begin
          msc_dec.mm = MM_MAX;
          hours_dec  = hours_q - HOURS_W'(1);
        end
      end
    end
  end

`ifdef TIMER_AUTO_RELOAD_EN
  logic [HOURS_W-1:0] rel_hours_q;
  msc_t               rel_msc_q;

  // Reload register captures every accepted LOAD value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rel_hours_q <= '0;
      rel_msc_q   <= '0;
    end else if (cmd_en_i && (cmd_op_i == OP_LOAD)) begin
      rel_hours_q <= load_hours_i;
      rel_msc_q   <= load_msc_i;
    end
  end

  assign rel_hours = rel_hours_q;
  assign rel_msc   = rel_msc_q;
  // A zero reload value would re-expire forever, so it rings like a one-shot.
  assign reload_ok = (rel_hours_q != '0) || (rel_msc_q != '0);
`else
  assign rel_hours = '0;
  assign rel_msc   = '0;
  assign reload_ok = 1'b0;
`endif

  // Where an expiring channel goes next and what its count becomes.
  always_comb begin
    exp_state = ST_RINGING;
    exp_hours = '0;
    exp_msc   = '0;
    if (reload_ok) begin
      exp_state = ST_RUNNING;
      exp_hours = rel_hours;
      exp_msc   = rel_msc;
    end
  end

  // Channel FSM with count and ring flag; commands override the tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= ST_IDLE;
      hours_q <= '0;
      msc_q   <= '0;
      ring_q  <= 1'b0;
    end else if (cmd_en_i) begin
      case (cmd_op_i)
        OP_LOAD: begin
          hours_q <= load_hours_i;
          msc_q   <= load_msc_i;
          ring_q  <= 1'b0;
          state_q <= ST_LOADED;
        end
        OP_START: begin
          if ((state_q == ST_LOADED) || (state_q == ST_PAUSED)) begin
            if (is_zero) begin
              ring_q  <= 1'b1;
              hours_q <= exp_hours;
              msc_q   <= exp_msc;
              state_q <= exp_state;
            end else begin
              state_q <= ST_RUNNING;
            end
          end
        end
        OP_PAUSE: begin
          if (state_q == ST_RUNNING) state_q <= ST_PAUSED;
        end
        OP_CLEAR: begin
          hours_q <= '0;
          msc_q   <= '0;
          ring_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        OP_ACK: begin
          if (state_q == ST_RINGING) begin
            ring_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (state_q == ST_RUNNING) begin
            // Auto-reloading channel acknowledged while still counting.
            ring_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end else if (tick_i && (state_q == ST_RUNNING)) begin
      if (is_zero) begin
        ring_q  <= 1'b1;
        hours_q <= exp_hours;
        msc_q   <= exp_msc;
        state_q <= exp_state;
      end else begin
        hours_q <= hours_dec;
        msc_q   <= msc_dec;
      end
    end
  end

  assign hours_o   = hours_q;
  assign msc_o     = msc_q;
  assign running_o = (state_q == ST_RUNNING);
  assign ring_o    = ring_q;

endmodule

// File: rtl/countdown_timer_bank.sv
// Bank of N_CHANNELS countdown timers sharing one centisecond tick.
// Holds the tick prescaler, command validation/steering and the registered
// readback mux; each channel lives in timer_channel.
// Build option TIMER_AUTO_RELOAD_EN selects auto-reload on expiry.
module countdown_timer_bank
  import timer_pkg::*;
#(
  parameter int N_CHANNELS = 4,
  parameter int CLK_DIV    = 1000000,
  parameter int HOURS_W    = 5,
  parameter int CH_W       = 2
) (
  input  logic                  clockSignal,
  input  logic                  resetN,
  countdown_timer_bank_if.slave cmd,
  input  logic [CH_W-1:0]       rdChannel,
  output logic [HOURS_W-1:0]    rdHours,
  output logic [5:0]            rdMinutes,
  output logic [5:0]            rdSeconds,
  output logic [6:0]            rdCentis,
  output logic [N_CHANNELS-1:0] running,
  output logic [N_CHANNELS-1:0] ringSound,
  output logic                  tickPulse
);

  localparam int PW      = $clog2(CLK_DIV);
  // Every encodable channel index gets a slot; slots past N_CHANNELS read 0.
  localparam int N_SLOTS = 2 ** CH_W;

  logic [PW-1:0] presc_q;
  logic          tick;

  logic          op_ok;
  logic          chan_ok;
  logic          fields_ok;
  logic          cmd_accept;
  logic          cmd_reject;
  logic          cmd_error_q;
  msc_t          load_msc;

  logic [HOURS_W-1:0] ch_hours [N_SLOTS];
  msc_t               ch_msc   [N_SLOTS];

  logic [HOURS_W-1:0] rd_hours_q;
  msc_t               rd_msc_q;

  assign tick      = (presc_q == PW'(CLK_DIV - 1));
  assign tickPulse = tick;

  // Centisecond prescaler: 0..CLK_DIV-1, tick on the terminal count.
  always_ff @(posedge clockSignal) begin
    if (!resetN) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  assign load_msc = {cmd.loadMinutes, cmd.loadSeconds, cmd.loadCentis};

  // Command validation; a NOP is neither accepted nor an error.
  always_comb begin
    op_ok      = (cmd.cmdOp <= 3'(OP_ACK));
    chan_ok    = (32'(cmd.cmdChannel) < 32'(N_CHANNELS));
    fields_ok  = (cmd.cmdOp != 3'(OP_LOAD)) || msc_fields_ok(load_msc);
    cmd_accept = cmd.cmdValid && (cmd.cmdOp != 3'(OP_NOP)) && op_ok && chan_ok && fields_ok;
    cmd_reject = cmd.cmdValid && (cmd.cmdOp != 3'(OP_NOP)) && !(op_ok && chan_ok && fields_ok);
  end

  // Rejected commands produce a one-cycle error pulse and nothing else.
  always_ff @(posedge clockSignal) begin
    if (!resetN) begin
      cmd_error_q <= 1'b0;
    end else begin
      cmd_error_q <= cmd_reject;
    end
  end

  assign cmd.cmdError = cmd_error_q;

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_ch
    if (i < N_CHANNELS) begin : g_live
      timer_channel #(
        .HOURS_W (HOURS_W)
      ) u_channel (
        .clk          (clockSignal),
        .rst_n        (resetN),
        .tick_i       (tick),
        .cmd_en_i     (cmd_accept && (cmd.cmdChannel == CH_W'(i))),
        .cmd_op_i     (cmd_op_e'(cmd.cmdOp)),
        .load_hours_i (cmd.loadHours),
        .load_msc_i   (load_msc),
        .hours_o      (ch_hours[i]),
        .msc_o        (ch_msc[i]),
        .running_o    (running[i]),
        .ring_o       (ringSound[i])
      );
    end else begin : g_pad
      assign ch_hours[i] = '0;
      assign ch_msc[i]   = '0;
    end
  end

  // Registered readback of the selected channel's remaining time.
  always_ff @(posedge clockSignal) begin
    if (!resetN) begin
      rd_hours_q <= '0;
      rd_msc_q   <= '0;
    end else begin
      rd_hours_q <= ch_hours[rdChannel];
      rd_msc_q   <= ch_msc[rdChannel];
    end
  end

  assign rdHours   = rd_hours_q;
  assign rdMinutes = rd_msc_q.mm;
  assign rdSeconds = rd_msc_q.ss;
  assign rdCentis  = rd_msc_q.cc;

endmodule

// File: tb/tb_countdown_timer_bank.sv
// Directed bench for countdown_timer_bank (CLK_DIV=4, N_CHANNELS=4, CH_W=3).
// A table of command vectors covers LOAD/CLEAR/ignored ops and rejections;
// hand sequences cover ticking, pause, expiry, tick/command collision, reset.
// Expectations follow TIMER_AUTO_RELOAD_EN when it is defined.
module tb_countdown_timer_bank;
  import timer_pkg::*;

  localparam int N_CH    = 4;
  localparam int DIV     = 4;
  localparam int HW      = 5;
  localparam int CW      = 3;

  logic            clk = 1'b0;
  logic            resetN;
  logic [CW-1:0]   rdChannel;
  logic [HW-1:0]   rdHours;
  logic [5:0]      rdMinutes;
  logic [5:0]      rdSeconds;
  logic [6:0]      rdCentis;
  logic [N_CH-1:0] running;
  logic [N_CH-1:0] ringSound;
  logic            tickPulse;

  int n_vec  = 0;
  int n_fail = 0;

  countdown_timer_bank_if #(.CH_W(CW), .HOURS_W(HW)) cmd_if ();

  countdown_timer_bank #(
    .N_CHANNELS (N_CH),
    .CLK_DIV    (DIV),
    .HOURS_W    (HW),
    .CH_W       (CW)
  ) dut (
    .clockSignal (clk),
    .resetN      (resetN),
    .cmd         (cmd_if),
    .rdChannel   (rdChannel),
    .rdHours     (rdHours),
    .rdMinutes   (rdMinutes),
    .rdSeconds   (rdSeconds),
    .rdCentis    (rdCentis),
    .running     (running),
    .ringSound   (ringSound),
    .tickPulse   (tickPulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [2:0] ch;
    int         h, m, s, c;
    logic [2:0] rd;
    logic       err;
    int         eh, em, es, ec;
  } vec_t;

  vec_t tbl [13];

  // One clock, then settle past the edge before sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_time(input string name, input int h, input int m, input int s, input int c);
    n_vec++;
    if ((rdHours !== HW'(h)) || (rdMinutes !== 6'(m)) || (rdSeconds !== 6'(s)) || (rdCentis !== 7'(c))) begin
      n_fail++;
      $display("FAIL %s: got %0d:%0d:%0d.%0d, expected %0d:%0d:%0d.%0d",
               name, rdHours, rdMinutes, rdSeconds, rdCentis, h, m, s, c);
    end
  endtask

  // Present one command for exactly one clock; state reflects it on return.
  task automatic send(input logic [2:0] op, input logic [2:0] ch,
                      input int h, input int m, input int s, input int c);
    cmd_if.cmdOp       = op;
    cmd_if.cmdChannel  = ch;
    cmd_if.loadHours   = HW'(h);
    cmd_if.loadMinutes = 6'(m);
    cmd_if.loadSeconds = 6'(s);
    cmd_if.loadCentis  = 7'(c);
    cmd_if.cmdValid    = 1'b1;
    cyc();
    cmd_if.cmdValid    = 1'b0;
    cmd_if.cmdOp       = 3'd0;
  endtask

  // Return in the cycle where tickPulse is high (next edge is a tick edge).
  task automatic wait_tick();
    int budget = 0;
    while ((tickPulse !== 1'b1) && (budget < 4 * DIV)) begin
      cyc();
      budget++;
    end
    if (tickPulse !== 1'b1) begin
      n_vec++;
      n_fail++;
      $display("FAIL tick_timeout: no tickPulse within %0d cycles", 4 * DIV);
    end
  endtask

  // Let n tick edges pass; returns just after the last one.
  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      wait_tick();
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          op    ch    h   m   s   c    rd    err  eh  em  es  ec
    tbl[0]  = '{3'd1, 3'd0, 1,  2,  3,  4,   3'd0, 1'b0, 1,  2,  3,  4};
    tbl[1]  = '{3'd1, 3'd1, 0,  0,  60, 0,   3'd0, 1'b1, 1,  2,  3,  4};
    tbl[2]  = '{3'd1, 3'd2, 0,  60, 0,  0,   3'd2, 1'b1, 0,  0,  0,  0};
    tbl[3]  = '{3'd1, 3'd3, 0,  0,  0,  100, 3'd3, 1'b1, 0,  0,  0,  0};
    tbl[4]  = '{3'd7, 3'd0, 0,  0,  0,  0,   3'd0, 1'b1, 1,  2,  3,  4};
    tbl[5]  = '{3'd6, 3'd0, 0,  0,  0,  0,   3'd0, 1'b1, 1,  2,  3,  4};
    tbl[6]  = '{3'd1, 3'd5, 1,  1,  1,  1,   3'd5, 1'b1, 0,  0,  0,  0};
    tbl[7]  = '{3'd1, 3'd3, 31, 59, 59, 99,  3'd3, 1'b0, 31, 59, 59, 99};
    tbl[8]  = '{3'd3, 3'd3, 0,  0,  0,  0,   3'd3, 1'b0, 31, 59, 59, 99};
    tbl[9]  = '{3'd5, 3'd3, 0,  0,  0,  0,   3'd3, 1'b0, 31, 59, 59, 99};
    tbl[10] = '{3'd4, 3'd3, 0,  0,  0,  0,   3'd3, 1'b0, 0,  0,  0,  0};
    tbl[11] = '{3'd0, 3'd0, 0,  0,  0,  0,   3'd0, 1'b0, 1,  2,  3,  4};
    tbl[12] = '{3'd4, 3'd0, 0,  0,  0,  0,   3'd0, 1'b0, 0,  0,  0,  0};

    resetN             = 1'b0;
    rdChannel          = '0;
    cmd_if.cmdValid    = 1'b0;
    cmd_if.cmdOp       = 3'd0;
    cmd_if.cmdChannel  = '0;
    cmd_if.loadHours   = '0;
    cmd_if.loadMinutes = '0;
    cmd_if.loadSeconds = '0;
    cmd_if.loadCentis  = '0;

    // Reset state.
    repeat (3) cyc();
    check("reset_running", 32'(running), 0);
    check("reset_ring", 32'(ringSound), 0);
    check("reset_err", 32'(cmd_if.cmdError), 0);
    check("reset_tick", 32'(tickPulse), 0);
    check_time("reset_rd", 0, 0, 0, 0);
    resetN = 1'b1;

    // Command table: no channel is running, so ticks do not disturb counts.
    for (int i = 0; i < 13; i++) begin
      rdChannel = tbl[i].rd;
      send(tbl[i].op, tbl[i].ch, tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].c);
      check($sformatf("v%0d_err", i), 32'(cmd_if.cmdError), 32'(tbl[i].err));
      cyc();
      check($sformatf("v%0d_err_pulse", i), 32'(cmd_if.cmdError), 0);
      check_time($sformatf("v%0d_rd", i), tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].ec);
      check($sformatf("v%0d_running", i), 32'(running), 0);
      check($sformatf("v%0d_ring", i), 32'(ringSound), 0);
    end

    // Reset in the middle of a run.
    rdChannel = 3'd0;
    send(3'd1, 3'd0, 0, 0, 5, 0);
    send(3'd2, 3'd0, 0, 0, 0, 0);
    run_ticks(1);
    cyc();
    check("mid_running_before", 32'(running[0]), 1);
    check_time("mid_rd_before", 0, 0, 4, 99);
    resetN = 1'b0;
    cyc();
    resetN = 1'b1;
    check("mid_running_after", 32'(running), 0);
    check("mid_ring_after", 32'(ringSound), 0);
    check("mid_tick_after", 32'(tickPulse), 0);
    check_time("mid_rd_after", 0, 0, 0, 0);
    cyc();
    check_time("mid_count_cleared", 0, 0, 0, 0);

    // Borrow, pause, resume on ch1.
    rdChannel = 3'd1;
    send(3'd1, 3'd1, 0, 1, 0, 0);
    send(3'd2, 3'd1, 0, 0, 0, 0);
    run_ticks(1);
    cyc();
    check_time("ch1_borrow", 0, 0, 59, 99);
    send(3'd3, 3'd1, 0, 0, 0, 0);
    run_ticks(10);
    cyc();
    check_time("ch1_paused", 0, 0, 59, 99);
    check("ch1_paused_running", 32'(running[1]), 0);
    send(3'd2, 3'd1, 0, 0, 0, 0);
    run_ticks(1);
    cyc();
    check_time("ch1_resumed", 0, 0, 59, 98);
    check("ch1_resumed_running", 32'(running[1]), 1);

    // Expiry and acknowledge on ch2.
    rdChannel = 3'd2;
    send(3'd1, 3'd2, 0, 0, 0, 2);
    send(3'd2, 3'd2, 0, 0, 0, 0);
    run_ticks(2);
    cyc();
    check_time("ch2_at_zero", 0, 0, 0, 0);
    check("ch2_ring_early", 32'(ringSound[2]), 0);
    run_ticks(1);
    check("ch2_ring", 32'(ringSound[2]), 1);
`ifdef TIMER_AUTO_RELOAD_EN
    check("ch2_running_expired", 32'(running[2]), 1);
`else
    check("ch2_running_expired", 32'(running[2]), 0);
`endif
    send(3'd5, 3'd2, 0, 0, 0, 0);
    check("ch2_ack_ring", 32'(ringSound[2]), 0);
    send(3'd2, 3'd2, 0, 0, 0, 0);
`ifdef TIMER_AUTO_RELOAD_EN
    check("ch2_after_ack_running", 32'(running[2]), 1);
`else
    check("ch2_idle_start_ignored", 32'(running[2]), 0);
`endif
    send(3'd4, 3'd2, 0, 0, 0, 0);

    // PAUSE landing on a tick edge: the decrement is skipped.
    rdChannel = 3'd3;
    send(3'd1, 3'd3, 0, 0, 0, 50);
    send(3'd2, 3'd3, 0, 0, 0, 0);
    wait_tick();
    send(3'd3, 3'd3, 0, 0, 0, 0);
    cyc();
    check_time("ch3_pause_on_tick", 0, 0, 0, 50);
    check("ch3_paused", 32'(running[3]), 0);
    run_ticks(2);
    cyc();
    check_time("ch3_still_paused", 0, 0, 0, 50);

    // START with a zero count expires immediately.
    rdChannel = 3'd1;
    send(3'd1, 3'd1, 0, 0, 0, 0);
    send(3'd2, 3'd1, 0, 0, 0, 0);
    check("ch1_zero_start_ring", 32'(ringSound[1]), 1);
    check("ch1_zero_start_running", 32'(running[1]), 0);

    // Expiry behaviour with a non-zero reload value on ch0.
    rdChannel = 3'd0;
    send(3'd1, 3'd0, 0, 0, 0, 3);
    send(3'd2, 3'd0, 0, 0, 0, 0);
    run_ticks(3);
    cyc();
    check_time("ch0_at_zero", 0, 0, 0, 0);
    check("ch0_ring_early", 32'(ringSound[0]), 0);
    run_ticks(1);
    check("ch0_ring", 32'(ringSound[0]), 1);
    cyc();
`ifdef TIMER_AUTO_RELOAD_EN
    check("ch0_running_expired", 32'(running[0]), 1);
    check_time("ch0_reloaded", 0, 0, 0, 3);
    send(3'd5, 3'd0, 0, 0, 0, 0);
    check("ch0_ack_ring", 32'(ringSound[0]), 0);
    check("ch0_ack_running", 32'(running[0]), 1);
`else
    check("ch0_running_expired", 32'(running[0]), 0);
    check_time("ch0_held_zero", 0, 0, 0, 0);
    send(3'd5, 3'd0, 0, 0, 0, 0);
    check("ch0_ack_ring", 32'(ringSound[0]), 0);
    check("ch0_ack_running", 32'(running[0]), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
